iigs_slow_sync: RTL and testbench



---
 rtl/iigs_slow_sync.sv | 115 +++++++++++
 tb/tb_iigs_slow_sync.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iigs_slow_sync.sv
// iigs_slow_sync: Mega II speed synchroniser for the IIgs core.
// Generates the 1.02 MHz slow-bus timebase from clk_sys and freezes the CPU
// through cpu_wait until a slow RAM / I/O access (or any access while in
// slow-speed mode) has spanned one complete, aligned slow cycle.
//
// Configuration macro: SLOW_LONG_CYCLE_EN
//   defined   - the last slow cycle of each scan line is SLOW_DIV+LONG_EXTRA
//               clocks long (the Apple II stretched cycle).
//   undefined - every slow cycle is SLOW_DIV clocks; slow_cycle still wraps.
module iigs_slow_sync #(
  parameter int SLOW_DIV    = 14,
  parameter int LONG_EXTRA  = 2,
  parameter int LINE_CYCLES = 65
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        fast_clk,
  input  logic        slow_req,
  input  logic        speed_fast,
  output logic        cpu_wait,
  output logic        slow_clk,
  output logic [3:0]  slow_phase,
  output logic [6:0]  slow_cycle,
  output logic [15:0] stall_cnt
);

  // Last phase index of a normal and of a stretched slow cycle.
  localparam logic [3:0] SHORT_LAST = 4'(SLOW_DIV - 1);
  localparam logic [3:0] LONG_LAST  = 4'(SLOW_DIV + LONG_EXTRA - 1);
  localparam logic [6:0] LAST_CYCLE = 7'(LINE_CYCLES - 1);

`ifdef SLOW_LONG_CYCLE_EN
  localparam logic STRETCH_EN = 1'b1;
`else
  localparam logic STRETCH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    ACCESS
  } state_t;

  state_t state;

  logic       line_end;
  logic [3:0] last_phase;
  logic       slow_start;

  // The stretched cycle only applies to the final slow cycle of a line.
  assign line_end   = (slow_cycle == LAST_CYCLE);
  assign last_phase = (STRETCH_EN && line_end) ? LONG_LAST : SHORT_LAST;

  // slow_clk is decoded purely from registered state, so it cannot glitch.
  assign slow_clk   = (slow_phase == last_phase);

  // A CPU cycle must be slowed if it hits slow RAM / I/O or we are in slow mode.
  assign slow_start = fast_clk & (slow_req | ~speed_fast);

  // Free-running slow-bus timebase: phase within the cycle, cycle within the line.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      slow_phase <= 4'd0;
      slow_cycle <= 7'd0;
    end else if (slow_clk) begin
      slow_phase <= 4'd0;
      slow_cycle <= line_end ? 7'd0 : slow_cycle + 7'd1;
    end else begin
      slow_phase <= slow_phase + 4'd1;
    end
  end

  // Stall FSM: hold the core until the access spans a full aligned slow cycle.
  // Strobes seen outside IDLE are ignored because the core is frozen then.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      cpu_wait <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (slow_start) begin
            cpu_wait <= 1'b1;
            state    <= slow_clk ? ACCESS : WAIT_START;
          end
        end
        WAIT_START: begin
          if (slow_clk) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (slow_clk) begin
            state    <= IDLE;
            cpu_wait <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cpu_wait <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of clocks spent with the core frozen.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (cpu_wait && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_iigs_slow_sync.sv
// tb_iigs_slow_sync: directed self-checking bench for iigs_slow_sync.
// Honours SLOW_LONG_CYCLE_EN the same way as the design.
module tb_iigs_slow_sync;

  localparam int SLOW_DIV    = 14;
  localparam int LONG_EXTRA  = 2;
  localparam int LINE_CYCLES = 65;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        fast_clk = 1'b0;
  logic        slow_req = 1'b0;
  logic        speed_fast = 1'b1;
  logic        cpu_wait;
  logic        slow_clk;
  logic [3:0]  slow_phase;
  logic [6:0]  slow_cycle;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int m_phase = 0;
  int m_cycle = 0;
  int exp_total = 0;
  bit timed_out = 0;

  iigs_slow_sync #(
    .SLOW_DIV(SLOW_DIV),
    .LONG_EXTRA(LONG_EXTRA),
    .LINE_CYCLES(LINE_CYCLES)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .fast_clk(fast_clk),
    .slow_req(slow_req),
    .speed_fast(speed_fast),
    .cpu_wait(cpu_wait),
    .slow_clk(slow_clk),
    .slow_phase(slow_phase),
    .slow_cycle(slow_cycle),
    .stall_cnt(stall_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Length in clocks of slow cycle c of the line.
  function automatic int len_of(input int c);
`ifdef SLOW_LONG_CYCLE_EN
    return (c == LINE_CYCLES - 1) ? SLOW_DIV + LONG_EXTRA : SLOW_DIV;
`else
    return SLOW_DIV;
`endif
  endfunction

  // Expected stall for a strobe at phase p of cycle c.
  function automatic int exp_stall(input int p, input int c);
    int l0;
    int l1;
    l0 = len_of(c);
    l1 = len_of((c == LINE_CYCLES - 1) ? 0 : c + 1);
    return (p == l0 - 1) ? l1 : (l0 - 1 - p) + l1;
  endfunction

  // Reference timebase model.
  always @(posedge clk_sys) begin
    if (reset) begin
      m_phase <= 0;
      m_cycle <= 0;
    end else if (m_phase == len_of(m_cycle) - 1) begin
      m_phase <= 0;
      m_cycle <= (m_cycle == LINE_CYCLES - 1) ? 0 : m_cycle + 1;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_model(input int p, input int c);
    timed_out = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_phase == p && (c < 0 || m_cycle == c)) return;
      tick();
    end
    timed_out = 1;
  endtask

  // Caller has raised fast_clk for the current cycle; count the stall length.
  task automatic measure(input bit poke, output int n);
    n = 0;
    tick();
    fast_clk = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cpu_wait !== 1'b1) begin
        fast_clk = 1'b0;
        return;
      end
      n++;
      fast_clk = (poke && i == 3);
      tick();
    end
    fast_clk = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (cpu_wait !== 1'b0 || slow_clk !== 1'b0 || slow_phase !== 4'd0 ||
        slow_cycle !== 7'd0 || stall_cnt !== 16'd0)
      begin
        errors++;
        $display("[TB] FAIL reset_state: got wait=%b clk=%b ph=%0d cyc=%0d cnt=%0d expected all 0",
                 cpu_wait, slow_clk, slow_phase, slow_cycle, stall_cnt);
      end
    reset = 1'b0;
    exp_total = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      checks++;
      if (slow_phase !== 4'(i % 14) || slow_clk !== ((i % 14) == 13) || slow_cycle !== 7'(i / 14)) begin
        errors++;
        $display("[TB] FAIL timebase_cycle%0d: got ph=%0d clk=%b cyc=%0d expected ph=%0d clk=%b cyc=%0d",
                 i, slow_phase, slow_clk, slow_cycle, i % 14, (i % 14) == 13, i / 14);
      end
    end
  endtask

  task automatic test_slow_access(input int p, input bit poke, input string name);
    int n;
    int e;
    speed_fast = 1'b1;
    wait_model(p, -1);
    checks++;
    if (timed_out) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got no phase %0d expected phase reached", name, p);
    end
    e = exp_stall(m_phase, m_cycle);
    fast_clk = 1'b1;
    slow_req = 1'b1;
    measure(poke, n);
    slow_req = 1'b0;
    exp_total += e;
    checks++;
    if (n != e) begin
      errors++;
      $display("[TB] FAIL %s_len: got %0d expected %0d", name, n, e);
    end
    checks++;
    if (stall_cnt !== 16'(exp_total)) begin
      errors++;
      $display("[TB] FAIL %s_cnt: got %0d expected %0d", name, stall_cnt, exp_total);
    end
    checks++;
    if (slow_phase !== 4'(m_phase)) begin
      errors++;
      $display("[TB] FAIL %s_phase: got %0d expected %0d", name, slow_phase, m_phase);
    end
  endtask

  task automatic test_no_slow();
    speed_fast = 1'b1;
    slow_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      fast_clk = 1'b1;
      tick();
      fast_clk = 1'b0;
      checks++;
      if (cpu_wait !== 1'b0) begin
        errors++;
        $display("[TB] FAIL no_slow_wait%0d: got %b expected 0", k, cpu_wait);
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 16'(exp_total)) begin
      errors++;
      $display("[TB] FAIL no_slow_cnt: got %0d expected %0d", stall_cnt, exp_total);
    end
  endtask

  task automatic test_slow_mode();
    int n;
    int e;
    speed_fast = 1'b0;
    slow_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (k * 3 + 1) tick();
      e = exp_stall(m_phase, m_cycle);
      fast_clk = 1'b1;
      measure(1'b0, n);
      exp_total += e;
      checks++;
      if (n != e) begin
        errors++;
        $display("[TB] FAIL slow_mode_len%0d: got %0d expected %0d", k, n, e);
      end
    end
    checks++;
    if (stall_cnt !== 16'(exp_total)) begin
      errors++;
      $display("[TB] FAIL slow_mode_cnt: got %0d expected %0d", stall_cnt, exp_total);
    end
    speed_fast = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    int e;
    speed_fast = 1'b1;
    slow_req = 1'b1;
    repeat (2) tick();
    e = exp_stall(m_phase, m_cycle);
    fast_clk = 1'b1;
    measure(1'b0, n);
    exp_total += e;
    checks++;
    if (n != e) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %0d expected %0d", n, e);
    end
    e = exp_stall(m_phase, m_cycle);
    fast_clk = 1'b1;
    measure(1'b0, n);
    exp_total += e;
    slow_req = 1'b0;
    checks++;
    if (n != e) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %0d expected %0d", n, e);
    end
    checks++;
    if (stall_cnt !== 16'(exp_total)) begin
      errors++;
      $display("[TB] FAIL b2b_cnt: got %0d expected %0d", stall_cnt, exp_total);
    end
  endtask

  task automatic test_long_cycle();
    int n;
    int e;
`ifdef SLOW_LONG_CYCLE_EN
    e = 16;
`else
    e = 14;
`endif
    speed_fast = 1'b1;
    wait_model(13, 63);
    checks++;
    if (timed_out) begin
      errors++;
      $display("[TB] FAIL long_timeout: got no cycle 63 expected cycle 63 reached");
    end
    fast_clk = 1'b1;
    slow_req = 1'b1;
    measure(1'b0, n);
    slow_req = 1'b0;
    exp_total += e;
    checks++;
    if (n != e) begin
      errors++;
      $display("[TB] FAIL long_len: got %0d expected %0d", n, e);
    end
    checks++;
    if (slow_cycle !== 7'd0 || slow_phase !== 4'd0) begin
      errors++;
      $display("[TB] FAIL long_wrap: got cyc=%0d ph=%0d expected cyc=0 ph=0", slow_cycle, slow_phase);
    end
  endtask

  task automatic test_reset_mid_stall();
    int n;
    speed_fast = 1'b1;
    slow_req = 1'b1;
    fast_clk = 1'b1;
    tick();
    fast_clk = 1'b0;
    slow_req = 1'b0;
    repeat (4) tick();
    checks++;
    if (cpu_wait !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_stall_wait: got %b expected 1", cpu_wait);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (cpu_wait !== 1'b0 || stall_cnt !== 16'd0 || slow_phase !== 4'd0 || slow_cycle !== 7'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_state: got wait=%b cnt=%0d ph=%0d cyc=%0d expected all 0",
               cpu_wait, stall_cnt, slow_phase, slow_cycle);
    end
    reset = 1'b0;
    exp_total = 0;
    tick();
    checks++;
    if (slow_phase !== 4'd1) begin
      errors++;
      $display("[TB] FAIL mid_restart_phase: got %0d expected 1", slow_phase);
    end
    slow_req = 1'b1;
    fast_clk = 1'b1;
    measure(1'b0, n);
    slow_req = 1'b0;
    checks++;
    if (n != 26 || stall_cnt !== 16'd26) begin
      errors++;
      $display("[TB] FAIL mid_after_reset: got len=%0d cnt=%0d expected len=26 cnt=26", n, stall_cnt);
    end
  endtask

  initial begin
    $display("[TB] starting iigs_slow_sync bench");
    test_reset();
    test_slow_access(5, 1'b1, "phase5");
    test_slow_access(13, 1'b0, "phase13");
    test_no_slow();
    test_slow_mode();
    test_back_to_back();
    test_long_cycle();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
